uart_rx_fifo: RTL

Receive-side buffer placed directly downstream of the UART receiver. Captures each completed character (data plus break indication) on the receiver's one-cycle valid strobe and stores it in a synchronous first-word-fall-through FIFO. Presents characters to the SoC bus/CPU side through a valid/ready interface. Generates level-threshold, idle-timeout and overflow status for interrupt logic.

---
 rtl/uart_rx_fifo.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT FIFO behind the UART receiver: stores {break, data} per character and
// raises level-threshold, idle-timeout and sticky overflow status for interrupt logic.
module uart_rx_fifo #(
    parameter int unsigned PAYLOAD_BITS   = 8,
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned THRESH         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx_valid,
    input  logic [PAYLOAD_BITS-1:0]   rx_data,
    input  logic                      rx_break,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [PAYLOAD_BITS-1:0]   rd_data,
    output logic                      rd_break,
    input  logic                      flush,
    input  logic                      ovf_clr,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      thresh_irq,
    output logic                      rx_timeout,
    output logic                      overflow
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = PtrW + 1;
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
    localparam logic [LvlW-1:0] LvlFull   = LvlW'(DEPTH);
    localparam logic [LvlW-1:0] LvlThresh = LvlW'(THRESH);
    localparam logic [CntW-1:0] CntMax    = CntW'(TIMEOUT_CYCLES - 1);

    logic [PAYLOAD_BITS:0] r_mem [DEPTH];
    logic [PtrW-1:0]       r_wr_ptr;
    logic [PtrW-1:0]       r_rd_ptr;
    logic [LvlW-1:0]       r_level;
    logic [CntW-1:0]       r_cnt;
    logic                  r_thresh;
    logic                  r_timeout;
    logic                  r_overflow;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_ovf_set;
    logic [PAYLOAD_BITS:0] w_head;
    logic [PtrW-1:0]       w_wr_ptr_d;
    logic [PtrW-1:0]       w_rd_ptr_d;
    logic [LvlW-1:0]       w_level_d;
    logic [CntW-1:0]       w_cnt_d;
    logic                  w_thresh_d;
    logic                  w_timeout_d;
    logic                  w_ovf_d;

    assign w_empty   = (r_level == '0);
    assign w_full    = (r_level == LvlFull);
    assign w_pop     = rd_ready && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push    = rx_valid && (!w_full || w_pop);
    assign w_ovf_set = rx_valid && w_full && !w_pop && !flush;
    assign w_head    = r_mem[r_rd_ptr];

    always_comb begin
        w_wr_ptr_d = r_wr_ptr;
        w_rd_ptr_d = r_rd_ptr;
        w_level_d  = r_level;
        if (flush) begin
            w_wr_ptr_d = '0;
            w_rd_ptr_d = '0;
            w_level_d  = '0;
        end else begin
            if (w_push) begin
                w_wr_ptr_d = r_wr_ptr + PtrW'(1);
            end
            if (w_pop) begin
                w_rd_ptr_d = r_rd_ptr + PtrW'(1);
            end
            if (w_push && !w_pop) begin
                w_level_d = r_level + LvlW'(1);
            end else if (w_pop && !w_push) begin
                w_level_d = r_level - LvlW'(1);
            end
        end
    end

    always_comb begin
        w_cnt_d = r_cnt;
        if (w_push || w_pop || flush || w_empty) begin
            w_cnt_d = '0;
        end else if (r_cnt != CntMax) begin
            w_cnt_d = r_cnt + CntW'(1);
        end
    end

    always_comb begin
        w_timeout_d = r_timeout;
        if (w_pop || flush || w_empty) begin
            w_timeout_d = 1'b0;
        end else if (w_cnt_d == CntMax) begin
            w_timeout_d = 1'b1;
        end
    end

    always_comb begin
        w_thresh_d = (w_level_d >= LvlThresh);
        w_ovf_d    = r_overflow;
        if (w_ovf_set) begin
            w_ovf_d = 1'b1;
        end else if (ovf_clr) begin
            w_ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_wr_ptr] <= {rx_break, rx_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_cnt      <= '0;
            r_thresh   <= 1'b0;
            r_timeout  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_d;
            r_rd_ptr   <= w_rd_ptr_d;
            r_level    <= w_level_d;
            r_cnt      <= w_cnt_d;
            r_thresh   <= w_thresh_d;
            r_timeout  <= w_timeout_d;
            r_overflow <= w_ovf_d;
        end
    end

    // Head outputs read as zero when empty so reset and flush leave them clean.
    assign rd_valid   = !w_empty;
    assign rd_data    = w_empty ? '0 : w_head[PAYLOAD_BITS-1:0];
    assign rd_break   = w_empty ? 1'b0 : w_head[PAYLOAD_BITS];
    assign level      = r_level;
    assign thresh_irq = r_thresh;
    assign rx_timeout = r_timeout;
    assign overflow   = r_overflow;

endmodule
